// File: rtl/masked_dom_mul_pkg.sv
// Shared definitions for the DOM-masked GF(2^n) multiplier: share limits,
// randomness bookkeeping and the field reduction polynomials.
package masked_dom_mul_pkg;

    localparam int MIN_SHARES = 2;
    localparam int MAX_SHARES = 4;

    // Two-share packed words, share index outermost.
    typedef logic [1:0][0:0] shared_bv1_t;
    typedef logic [1:0][1:0] shared_bv2_t;
    typedef logic [1:0][3:0] shared_bv4_t;

    // Number of fresh random words one DOM-indep multiplication consumes.
    function automatic int num_dom_rand(input int d);
        return (d * (d - 1)) / 2;
    endfunction

    // Lexicographic index of pair (i,j), i<j, among all share pairs of n shares.
    function automatic int dom_rand_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Low-order bits of the reduction polynomial: x^2+x+1 for GF(4), x^4+x+1 for GF(16).
    function automatic logic [3:0] gf_poly_low(input int w);
        case (w)
            1:       return 4'b0001;
            2:       return 4'b0011;
            default: return 4'b0011;
        endcase
    endfunction

endpackage

// File: rtl/masked_dom_mul_generic_mul.sv
// Combinational GF(2^BIT_WIDTH) multiplier in polynomial basis
// (GF(2): AND, GF(4): x^2+x+1, GF(16): x^4+x+1).
module generic_mul
    import masked_dom_mul_pkg::*;
#(
    parameter int BIT_WIDTH = 2
) (
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    output logic [BIT_WIDTH-1:0] out_c
);

    localparam logic [BIT_WIDTH-1:0] POLY = BIT_WIDTH'(gf_poly_low(BIT_WIDTH));

    if (!(BIT_WIDTH == 1 || BIT_WIDTH == 2 || BIT_WIDTH == 4)) begin : g_illegal_width
        $error("generic_mul: BIT_WIDTH must be 1, 2 or 4");
    end

    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sh;

    // Shift-and-add: sh walks through a*x^i, reduced modulo the field polynomial.
    always_comb begin
        acc = '0;
        sh  = in_a;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            if (in_b[i]) begin
                acc = acc ^ sh;
            end
            sh = (sh << 1) ^ (sh[BIT_WIDTH-1] ? POLY : '0);
        end
        out_c = acc;
    end

endmodule

// File: rtl/masked_dom_mul.sv
// Registered DOM-indep masked GF(2^BIT_WIDTH) multiplier: all share-pair products
// are refreshed and registered per domain before any cross-domain compression.
module masked_dom_mul
    import masked_dom_mul_pkg::*;
#(
    parameter int BIT_WIDTH  = 2,
    parameter int NUM_SHARES = 2,
    parameter int NUM_RAND   = num_dom_rand(NUM_SHARES)
) (
    input  logic                             in_clock,
    input  logic                             in_reset,
    input  logic                             in_valid,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0]  in_a,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0]  in_b,
    input  logic [NUM_RAND*BIT_WIDTH-1:0]    in_random,
    output logic                             out_valid,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]  out_c
);

    if (NUM_SHARES < MIN_SHARES || NUM_SHARES > MAX_SHARES) begin : g_illegal_shares
        $error("masked_dom_mul: NUM_SHARES must be in 2..4");
    end

    if (NUM_RAND != num_dom_rand(NUM_SHARES)) begin : g_illegal_rand
        $error("masked_dom_mul: NUM_RAND is derived from NUM_SHARES and must not be overridden");
    end

    logic [BIT_WIDTH-1:0] prod   [NUM_SHARES][NUM_SHARES];
    logic [BIT_WIDTH-1:0] term_d [NUM_SHARES][NUM_SHARES];
    logic [BIT_WIDTH-1:0] term_q [NUM_SHARES][NUM_SHARES];
    logic                 valid_q;

    // term[i][j] lives in domain i; cross terms of pair (i,j) share one fresh mask r_k.
    for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_SHARES; gj++) begin : g_col
            generic_mul #(
                .BIT_WIDTH (BIT_WIDTH)
            ) u_mul (
                .in_a  (in_a[gi*BIT_WIDTH +: BIT_WIDTH]),
                .in_b  (in_b[gj*BIT_WIDTH +: BIT_WIDTH]),
                .out_c (prod[gi][gj])
            );

            if (gi == gj) begin : g_inner
                assign term_d[gi][gj] = prod[gi][gj];
            end else begin : g_cross
                localparam int K = (gi < gj) ? dom_rand_idx(gi, gj, NUM_SHARES)
                                             : dom_rand_idx(gj, gi, NUM_SHARES);
                assign term_d[gi][gj] = prod[gi][gj] ^ in_random[K*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_SHARES; i++) begin
                for (int j = 0; j < NUM_SHARES; j++) begin
                    term_q[i][j] <= '0;
                end
            end
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < NUM_SHARES; i++) begin
                    for (int j = 0; j < NUM_SHARES; j++) begin
                        term_q[i][j] <= term_d[i][j];
                    end
                end
            end
        end
    end

    // Compression sees registered terms only, so product glitches never reach out_c.
    always_comb begin
        out_c = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
                out_c[i*BIT_WIDTH +: BIT_WIDTH] = out_c[i*BIT_WIDTH +: BIT_WIDTH] ^ term_q[i][j];
            end
        end
    end

    assign out_valid = valid_q;

endmodule
